// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store front end for a word-only data memory (sub-word stores use read-modify-write).
// Response latency after accept: error 1, load/word store 2, sub-word store 3; one request in flight, no response backpressure.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           merge_q, merge_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  illegal;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign illegal = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign addr_aligned = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    ld_byte = mem_rd[7:0];
    case (addr_q[1:0])
      2'b01:   ld_byte = mem_rd[15:8];
      2'b10:   ld_byte = mem_rd[23:16];
      2'b11:   ld_byte = mem_rd[31:24];
      default: ld_byte = mem_rd[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = illegal;
          if (illegal) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_size == 2'b10) begin
            merge_d = req_wdata;
            state_d = WRITE;
          end else begin
            state_d = MERGE;
          end
        end
      end
      LOAD: begin
        case (size_q)
          2'b00:   rdata_d = {{24{signed_q & ld_byte[7]}}, ld_byte};
          2'b01:   rdata_d = {{16{signed_q & ld_half[15]}}, ld_half};
          default: rdata_d = mem_rd;
        endcase
        state_d = RESP;
      end
      MERGE: begin
        // Only the addressed lane is replaced; the other lanes come from the current memory word.
        merge_d = mem_rd;
        if (size_q == 2'b00) begin
          case (addr_q[1:0])
            2'b00:   merge_d[7:0]   = wdata_q[7:0];
            2'b01:   merge_d[15:8]  = wdata_q[7:0];
            2'b10:   merge_d[23:16] = wdata_q[7:0];
            default: merge_d[31:24] = wdata_q[7:0];
          endcase
        end else if (addr_q[1]) begin
          merge_d[31:16] = wdata_q[15:0];
        end else begin
          merge_d[15:0] = wdata_q[15:0];
        end
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Reset overrides the decoded outputs so an in-flight write is dropped on the same edge.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_a      = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    if (reset) begin
      req_ready = 1'b1;
    end else begin
      case (state_q)
        IDLE:  req_ready = 1'b1;
        LOAD:  mem_a = addr_aligned;
        MERGE: mem_a = addr_aligned;
        WRITE: begin
          mem_a  = addr_aligned;
          mem_we = 1'b1;
          mem_wd = merge_q;
        end
        RESP: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          resp_rdata = rdata_q;
        end
        default: req_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory plus a byte-array reference model of the load/store rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] dmem [0:63];
  logic [7:0]  ref_mem [0:255];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_dat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = dmem[mem_a[7:2]];
  always @(posedge clk) begin
    if (pl_en) dmem[pl_idx] <= pl_dat;
    else if (mem_we) dmem[mem_a[7:2]] <= mem_wd;
  end

  task automatic preload();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      w = (i == 4) ? 32'h8899AABB : $urandom;
      pl_en = 1'b1; pl_idx = 6'(i); pl_dat = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Reference: memory as a plain byte array, little-endian, value built by arithmetic.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] e_rd, output logic e_err, output int e_lat,
                       output int e_nwe, output logic [31:0] e_wa, output logic [31:0] e_wd);
    int n;
    int base;
    e_rd = 0; e_nwe = 0; e_wa = 0; e_wd = 0;
    n = 1 << size;
    base = int'(addr[7:0]);
    e_err = (size == 2'd3) || (addr % n != 0);
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      e_lat = 2;
      for (int i = 0; i < n; i++) e_rd = e_rd + (32'(ref_mem[base+i]) << (8*i));
      if (sgn && n < 4 && e_rd[8*n-1]) e_rd = e_rd - (32'd1 << (8*n));
    end else begin
      e_lat = (n == 4) ? 2 : 3;
      for (int i = 0; i < n; i++) ref_mem[base+i] = wd[8*i +: 8];
      e_nwe = 1;
      e_wa  = addr - (addr % 4);
      for (int i = 0; i < 4; i++) e_wd = e_wd + (32'(ref_mem[int'(e_wa[7:0])+i]) << (8*i));
    end
  endtask

  // Drives one request and records what the DUT did over the following cycles.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic err, output int nresp,
                       output int nwe, output logic [31:0] wa, output logic [31:0] wdat);
    int guard;
    lat = -1; rd = 0; err = 0; nresp = 0; nwe = 0; wa = 0; wdat = 0; guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_we) begin nwe++; wa = mem_a; wdat = mem_wd; end
      if (resp_valid) begin
        nresp++;
        if (lat < 0) begin lat = k; rd = resp_rdata; err = resp_err; end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000 || resp_rdata !== 0 || mem_a !== 0 || mem_wd !== 0) begin
      n_fail++;
      $display("FAIL reset_active: rdy=%b vld=%b err=%b we=%b rdata=%h a=%h wd=%h, want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, mem_we, resp_rdata, mem_a, mem_wd);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000 || resp_rdata !== 0 || mem_a !== 0 || mem_wd !== 0) begin
      n_fail++;
      $display("FAIL reset_after: rdy=%b vld=%b err=%b we=%b rdata=%h a=%h wd=%h, want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, mem_we, resp_rdata, mem_a, mem_wd);
    end
  endtask

  task automatic test_loads();
    logic [31:0] t_addr [0:4];
    logic [1:0]  t_size [0:4];
    logic        t_sgn  [0:4];
    logic [31:0] t_exp  [0:4];
    int lat, nresp, nwe;
    logic [31:0] rd, wa, wdat;
    logic err;
    preload();
    t_addr = '{32'h11, 32'h13, 32'h12, 32'h10, 32'h10};
    t_size = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    t_sgn  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t_exp  = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, t_size[i], t_sgn[i], t_addr[i], 32'h0, lat, rd, err, nresp, nwe, wa, wdat);
      n_checks++;
      if (rd !== t_exp[i] || err !== 1'b0 || lat != 2 || nresp != 1 || nwe != 0) begin
        n_fail++;
        $display("FAIL load_%0d: rdata=%h err=%b lat=%0d nresp=%0d nwe=%0d, want %h 0 2 1 0",
                 i, rd, err, lat, nresp, nwe, t_exp[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    int lat, nresp, nwe;
    logic [31:0] rd, wa, wdat;
    logic err;
    preload();
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h12345677, lat, rd, err, nresp, nwe, wa, wdat);
    n_checks++;
    if (nwe != 1 || wa !== 32'h10 || wdat !== 32'h8877AABB) begin
      n_fail++;
      $display("FAIL byte_store_write: nwe=%0d a=%h wd=%h, want 1 00000010 8877aabb", nwe, wa, wdat);
    end
    n_checks++;
    if (lat != 3 || err !== 1'b0 || rd !== 0 || nresp != 1) begin
      n_fail++;
      $display("FAIL byte_store_resp: lat=%0d err=%b rdata=%h nresp=%0d, want 3 0 0 1", lat, err, rd, nresp);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, err, nresp, nwe, wa, wdat);
    n_checks++;
    if (rd !== 32'h8877AABB || lat != 2) begin
      n_fail++;
      $display("FAIL byte_store_readback: rdata=%h lat=%0d, want 8877aabb 2", rd, lat);
    end
  endtask

  task automatic test_errors();
    logic        t_we   [0:2];
    logic [1:0]  t_size [0:2];
    logic [31:0] t_addr [0:2];
    int lat, nresp, nwe;
    logic [31:0] rd, wa, wdat;
    logic err;
    preload();
    t_we   = '{1'b1, 1'b0, 1'b0};
    t_size = '{2'd1, 2'd3, 2'd2};
    t_addr = '{32'h11, 32'h10, 32'h16};
    for (int i = 0; i < 3; i++) begin
      issue(t_we[i], t_size[i], 1'b1, t_addr[i], 32'hFFFFFFFF, lat, rd, err, nresp, nwe, wa, wdat);
      n_checks++;
      if (lat != 1 || err !== 1'b1 || rd !== 0 || nwe != 0 || nresp != 1) begin
        n_fail++;
        $display("FAIL error_%0d: lat=%0d err=%b rdata=%h nwe=%0d nresp=%0d, want 1 1 0 0 1",
                 i, lat, err, rd, nwe, nresp);
      end
    end
    n_checks++;
    if (dmem[4] !== 32'h8899AABB) begin
      n_fail++;
      $display("FAIL error_nowrite: word 0x10=%h, want 8899aabb", dmem[4]);
    end
  endtask

  task automatic test_back_to_back();
    preload();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h14; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_we = 1'b0; req_wdata = 32'h0;
    n_checks++;
    if (req_ready !== 1'b0 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_write_cycle: rdy=%b we=%b, want 0 1", req_ready, mem_we);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_resp_cycle: rdy=%b vld=%b err=%b, want 0 1 0", req_ready, resp_valid, resp_err);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: rdy=%b vld=%b, want 1 0", req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL b2b_load: vld=%b rdata=%h, want 1 deadbeef", resp_valid, resp_rdata);
    end
    for (int b = 0; b < 4; b++) ref_mem[20+b] = 8'(32'hDEADBEEF >> (8*b));
  endtask

  task automatic test_reset_mid_write();
    int nresp;
    int lat, nwe;
    logic [31:0] rd, wa, wdat;
    logic err;
    preload();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00000055;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_write_gate: we=%b, want 0", mem_we);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: rdy=%b, want 1", req_ready);
    end
    nresp = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) nresp++;
      @(negedge clk);
    end
    n_checks++;
    if (nresp != 0 || dmem[4] !== 32'h8899AABB) begin
      n_fail++;
      $display("FAIL rst_abort: nresp=%0d word=%h, want 0 8899aabb", nresp, dmem[4]);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, err, nresp, nwe, wa, wdat);
    n_checks++;
    if (rd !== 32'h8899AABB || lat != 2) begin
      n_fail++;
      $display("FAIL rst_readback: rdata=%h lat=%0d, want 8899aabb 2", rd, lat);
    end
  endtask

  task automatic test_random();
    int lat, nresp, nwe, e_lat, e_nwe, bad;
    logic [31:0] rd, wa, wdat, e_rd, e_wa, e_wd, addr, wd, w;
    logic err, e_err, we, sgn;
    logic [1:0] size;
    preload();
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom); sgn = 1'($urandom); size = 2'($urandom);
      addr = $urandom_range(0, 255); wd = $urandom;
      model(we, size, sgn, addr, wd, e_rd, e_err, e_lat, e_nwe, e_wa, e_wd);
      issue(we, size, sgn, addr, wd, lat, rd, err, nresp, nwe, wa, wdat);
      n_checks++;
      if (rd !== e_rd || err !== e_err || lat != e_lat || nresp != 1 || nwe != e_nwe ||
          (e_nwe == 1 && (wa !== e_wa || wdat !== e_wd))) begin
        n_fail++;
        $display("FAIL rand_%0d we=%b sz=%0d sgn=%b a=%h wd=%h: rdata=%h err=%b lat=%0d nresp=%0d nwe=%0d ma=%h mwd=%h, want %h %b %0d 1 %0d %h %h",
                 i, we, size, sgn, addr, wd, rd, err, lat, nresp, nwe, wa, wdat, e_rd, e_err, e_lat, e_nwe, e_wa, e_wd);
      end
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      if (dmem[i] !== w) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rand_mem_image: %0d words differ, want 0", bad);
    end
  endtask

  initial begin
    reset = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    test_reset();
    test_loads();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
